// File: rtl/fp_pkg.sv
// Shared single-precision FP definitions for the butterfly multiplier and adder/subtractor.
package fp_pkg;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_W     = 1 + FP_EXP_W + FP_MAN_W;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [FP_W-1:0] POS_INF = 32'h7F80_0000;
  localparam logic [FP_W-1:0] NEG_INF = 32'hFF80_0000;

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } fp_state_e;
endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
module fp_lzc #(
  parameter int W  = 28,
  parameter int CW = 5
) (
  input  logic [W-1:0]  in_i,
  output logic [CW-1:0] cnt_o
);
  // Ascending scan: the last hit is the highest set bit.
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++)
      if (in_i[i]) cnt_o = CW'(W - 1 - i);
  end
endmodule

// File: rtl/fp_add_sub.sv
// Multi-cycle IEEE-754 single-precision add/sub, one op in flight, str_sig/done_sig handshake.
module fp_add_sub
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     str_sig,
  input  logic                     op_sub,
  input  logic [EXP_W+MAN_W:0]     da_in1,
  input  logic [EXP_W+MAN_W:0]     da_in2,
  output logic [EXP_W+MAN_W:0]     da_out,
  output logic                     done_sig,
  output logic                     error
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int FW  = MAN_W + 4;   // {hidden, M, G, R, S}
  localparam int SW  = FW + 1;      // room for the carry out
  localparam int EW2 = EXP_W + 2;   // signed exponent headroom

  fp_state_e state_q, state_d;
  logic              str_q, op_q, start;
  logic [W-1:0]      a_q, b_q, pass_q, da_out_q;
  logic [FW-1:0]     mx_q, my_q, nm_q;
  logic [EXP_W-1:0]  ex_q;
  logic              sign_q, sub_q, inf_q, inf_neg_q, one_zero_q, zsum_q;
  logic [SW-1:0]     sum_q;
  logic signed [EW2-1:0] ne_q;
  logic              err_q, done_q;

  assign start = str_sig & ~str_q & (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ALIGN: exponent-zero operands are flushed to zero before the magnitude compare.
  logic [EXP_W-1:0] ea, eb, ex, ey, d;
  logic [MAN_W-1:0] ma, mb;
  logic             za, zb, sb_eff, swap;
  logic [FW-1:0]    mxn, myn, my_al;
  logic [2*FW-1:0]  wide;

  always_comb begin
    ea     = a_q[W-2:MAN_W];
    eb     = b_q[W-2:MAN_W];
    za     = (ea == '0);
    zb     = (eb == '0);
    ma     = za ? '0 : a_q[MAN_W-1:0];
    mb     = zb ? '0 : b_q[MAN_W-1:0];
    sb_eff = b_q[W-1] ^ op_q;
    swap   = {eb, mb} > {ea, ma};
    ex     = swap ? eb : ea;
    ey     = swap ? ea : eb;
    mxn    = swap ? {~zb, mb, 3'b000} : {~za, ma, 3'b000};
    myn    = swap ? {~za, ma, 3'b000} : {~zb, mb, 3'b000};
    d      = ex - ey;
    wide   = {myn, {FW{1'b0}}} >> d;
    if (d >= EXP_W'(FW)) my_al = {{(FW-1){1'b0}}, |myn};
    else                 my_al = wide[2*FW-1:FW] | {{(FW-1){1'b0}}, |wide[FW-1:0]};
  end

  // NORM: a carry out gives lz=0, i.e. the one-bit right shift with exp+1.
  logic [4:0]            lz;
  logic [SW-1:0]         norm;
  logic [FW-1:0]         nm_d;
  logic signed [EW2-1:0] ne_d;

  fp_lzc #(.W(SW), .CW(5)) u_lzc (.in_i(sum_q), .cnt_o(lz));

  always_comb begin
    norm = sum_q << lz;
    nm_d = {norm[SW-1:2], |norm[1:0]};
    ne_d = EW2'({2'b00, ex_q}) + EW2'(1) - EW2'(lz);
  end

  // ROUND: nearest-even on G/R/S, then result precedence.
  logic                  up, ovf, unf, err_d;
  logic [MAN_W+1:0]      rm;
  logic [MAN_W-1:0]      man_r;
  logic signed [EW2-1:0] re_d;
  logic [W-1:0]          res_d;

  always_comb begin
    up    = nm_q[2] & (nm_q[1] | nm_q[0] | nm_q[3]);
    rm    = {1'b0, nm_q[FW-1:3]} + {{(MAN_W+1){1'b0}}, up};
    re_d  = ne_q + EW2'(rm[MAN_W+1]);
    man_r = rm[MAN_W+1] ? rm[MAN_W:1] : rm[MAN_W-1:0];
    ovf   = (re_d >= $signed(EW2'(EXP_MAX)));
    unf   = re_d[EW2-1] | (re_d == '0);
    res_d = {sign_q, re_d[EXP_W-1:0], man_r};
    err_d = 1'b0;
    if (inf_q) begin
      res_d = inf_neg_q ? NEG_INF : POS_INF;
      err_d = 1'b1;
    end else if (zsum_q) begin
      res_d = '0;
    end else if (one_zero_q) begin
      res_d = pass_q;
    end else if (ovf) begin
      res_d = sign_q ? NEG_INF : POS_INF;
      err_d = 1'b1;
    end else if (unf) begin
      res_d = {sign_q, {(W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;   str_q <= 1'b0;   op_q <= 1'b0;
      a_q <= '0;  b_q <= '0;  pass_q <= '0;  da_out_q <= '0;
      mx_q <= '0; my_q <= '0; nm_q <= '0;  ex_q <= '0;  sum_q <= '0;  ne_q <= '0;
      sign_q <= 1'b0; sub_q <= 1'b0; inf_q <= 1'b0; inf_neg_q <= 1'b0;
      one_zero_q <= 1'b0; zsum_q <= 1'b0; err_q <= 1'b0; done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      str_q   <= str_sig;
      done_q  <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: if (start) begin
          a_q   <= da_in1;
          b_q   <= da_in2;
          op_q  <= op_sub;
          err_q <= 1'b0;
        end
        S_ALIGN: begin
          mx_q       <= mxn;
          my_q       <= my_al;
          ex_q       <= ex;
          sign_q     <= swap ? sb_eff : a_q[W-1];
          sub_q      <= a_q[W-1] ^ sb_eff;
          inf_q      <= (&ea) | (&eb);
          inf_neg_q  <= (&ea) ? a_q[W-1] : b_q[W-1];
          one_zero_q <= za ^ zb;
          pass_q     <= za ? {sb_eff, b_q[W-2:0]} : a_q;
        end
        S_ADD: sum_q <= sub_q ? ({1'b0, mx_q} - {1'b0, my_q})
                              : ({1'b0, mx_q} + {1'b0, my_q});
        S_NORM: begin
          nm_q   <= nm_d;
          ne_q   <= ne_d;
          zsum_q <= (sum_q == '0);
        end
        S_ROUND: begin
          da_out_q <= res_d;
          err_q    <= err_d;
        end
        default: ;
      endcase
    end
  end

  assign da_out   = da_out_q;
  assign done_sig = done_q;
  assign error    = err_q;
endmodule
